// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between NUM_REQ message sources, the TX arbiter and the UART serializer.
// master = sources/serializer side, slave = arbiter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 busy;
    logic                 timeout_pulse;

    modport master (
        output req, req_data, req_valid, req_last, tx_ready,
        input  req_ready, grant, tx_data, tx_valid, busy, timeout_pulse
    );

    modport slave (
        input  req, req_data, req_valid, req_last, tx_ready,
        output req_ready, grant, tx_data, tx_valid, busy, timeout_pulse
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular share of one UART TX byte stream; ARB_TIMEOUT_EN adds a stall-release timer.
// Grant 1 cycle after req; datapath is combinational; tx_ready passes straight to the owner's req_ready.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_gidx;

    logic               w_sel_found;
    logic [PTR_W-1:0]   w_sel_idx;
    logic [PTR_W:0]     w_cand;
    logic               w_hs;
    logic               w_last;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    // Search upward from rr_ptr+1 with an explicit wrap, so non-power-of-two NUM_REQ works.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_cand >= (PTR_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_sel_found && bus.req[w_cand[PTR_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        bus.tx_data   = 8'h00;
        bus.tx_valid  = 1'b0;
        bus.req_ready = '0;
        if (r_state == XFER) begin
            bus.tx_data           = bus.req_data[{r_gidx, 3'b000} +: 8];
            bus.tx_valid          = bus.req_valid[r_gidx];
            bus.req_ready[r_gidx] = bus.tx_ready;
        end
    end

    assign w_hs      = (r_state == XFER) && bus.tx_valid && bus.tx_ready;
    assign w_last    = bus.req_last[r_gidx];
    assign bus.grant = r_grant;
    assign bus.busy  = (r_state != IDLE);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_stall;
    logic             r_timeout_pulse;
    logic             w_expire;

    // Fires on the stall cycle that would bring the count to TIMEOUT_CYCLES.
    assign w_expire          = (r_stall == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_pulse = r_timeout_pulse;
`else
    assign bus.timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= PTR_W'(NUM_REQ - 1);
            r_gidx   <= '0;
`ifdef ARB_TIMEOUT_EN
            r_stall         <= '0;
            r_timeout_pulse <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout_pulse <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_sel_found) begin
                        r_state <= XFER;
                        r_gidx  <= w_sel_idx;
                        r_grant <= NUM_REQ'(1) << w_sel_idx;
`ifdef ARB_TIMEOUT_EN
                        r_stall <= '0;
`endif
                    end
                end
                XFER: begin
                    if (w_hs && w_last) begin
                        r_state  <= RELEASE;
                        r_grant  <= '0;
                        r_rr_ptr <= r_gidx;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (w_hs) begin
                        r_stall <= '0;
                    end else if (w_expire) begin
                        r_state         <= RELEASE;
                        r_grant         <= '0;
                        r_rr_ptr        <= r_gidx;
                        r_timeout_pulse <= 1'b1;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
`endif
                end
                RELEASE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter; random traffic is checked against a
// message-level round-robin model built from per-source message lists.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic put(input int i, input logic v, input logic l, input logic [7:0] d);
        bus.req_valid[i]       = v;
        bus.req_last[i]        = l;
        bus.req_data[8*i +: 8] = d;
    endtask

    task automatic idle_inputs();
        bus.req       = '0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.tx_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_grant(input string tag);
        for (int c = 0; c < 20; c++) begin
            if (bus.grant != '0) break;
            step();
        end
        chk(tag, {31'b0, bus.grant != '0}, 32'd1);
    endtask

    logic [8:0] src_mem [N][64];
    int         src_len [N];
    int         src_pos [N];
    int         mpos    [N];
    int         exp_own [$];
    logic [8:0] exp_byt [$];

    initial begin
        logic [7:0] m1 [3];
        logic [7:0] m3 [2];
        logic [3:0] pat;
        int exp_idx, nb, pulses, exp_g, nm, len, mptr, found, cidx, cyc;
        bit done_msg;

        m1[0] = 8'h4C; m1[1] = 8'h75; m1[2] = 8'h73;
        m3[0] = 8'hA5; m3[1] = 8'h5A;
        pat   = 4'b1001;

        // Reset state
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tpulse", bus.timeout_pulse, 0);
        chk("rst_txvalid", bus.tx_valid, 0);
        chk("rst_txdata", bus.tx_data, 0);
        chk("rst_reqready", bus.req_ready, 0);
        reset_n = 1'b1;

        // Single requester, 3-byte message
        bus.tx_ready = 1'b1;
        bus.req[0]   = 1'b1;
        put(0, 1'b1, 1'b0, m1[0]);
        step();
        for (int b = 0; b < 3; b++) begin
            put(0, 1'b1, b == 2, m1[b]);
            settle();
            chk("t1_grant", bus.grant, 4'b0001);
            chk("t1_data", bus.tx_data, m1[b]);
            chk("t1_valid", bus.tx_valid, 1);
            chk("t1_ready", bus.req_ready, 4'b0001);
            step();
        end
        bus.req[0] = 1'b0;
        put(0, 1'b0, 1'b0, 8'h00);
        settle();
        chk("t1_gap_grant", bus.grant, 0);
        chk("t1_gap_valid", bus.tx_valid, 0);
        chk("t1_gap_busy", bus.busy, 1);
        step();
        settle();
        chk("t1_idle_busy", bus.busy, 0);

        // Contention: all four request, one byte each
        do_reset();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.req[i] = 1'b1;
            put(i, 1'b1, 1'b1, 8'(i));
        end
        exp_idx = N - 1;
        for (int m = 0; m < 5; m++) begin
            exp_idx = (exp_idx + 1) % N;
            wait_grant("t2_wait");
            settle();
            chk("t2_grant", bus.grant, 32'(1) << exp_idx);
            chk("t2_data", bus.tx_data, exp_idx);
            chk("t2_valid", bus.tx_valid, 1);
            step();
        end
        idle_inputs();

        // Backpressure on a 2-byte message from requester 2
        bus.req[2]   = 1'b1;
        bus.tx_ready = 1'b1;
        put(2, 1'b1, 1'b0, m3[0]);
        put(0, 1'b1, 1'b1, 8'hEE);
        put(3, 1'b1, 1'b1, 8'hDD);
        wait_grant("t3_wait");
        nb = 0;
        for (int c = 0; c < 4; c++) begin
            bus.tx_ready = pat[c];
            put(2, 1'b1, nb == 1, m3[nb]);
            settle();
            chk("t3_grant", bus.grant, 4'b0100);
            chk("t3_ready", bus.req_ready, {29'b0, pat[c], 2'b00});
            chk("t3_data", bus.tx_data, m3[nb]);
            if (bus.tx_valid && bus.tx_ready) nb++;
            step();
        end
        chk("t3_hs_count", nb, 2);
        settle();
        chk("t3_release", bus.grant, 0);
        idle_inputs();

        // Owner drops req mid-message
        do_reset();
        bus.tx_ready = 1'b1;
        bus.req      = 4'b1010;
        put(1, 1'b1, 1'b0, 8'h10);
        put(3, 1'b1, 1'b1, 8'h33);
        wait_grant("t4_wait");
        for (int b = 0; b < 3; b++) begin
            put(1, 1'b1, b == 2, 8'h10 + 8'(b));
            if (b >= 1) bus.req[1] = 1'b0;
            settle();
            chk("t4_grant", bus.grant, 4'b0010);
            chk("t4_data", bus.tx_data, 8'h10 + 8'(b));
            step();
        end
        put(1, 1'b0, 1'b0, 8'h00);
        wait_grant("t4_wait_next");
        settle();
        chk("t4_next", bus.grant, 4'b1000);
        chk("t4_next_data", bus.tx_data, 8'h33);
        step();
        idle_inputs();

        // Reset in the middle of a message
        do_reset();
        bus.tx_ready = 1'b1;
        bus.req[0]   = 1'b1;
        put(0, 1'b1, 1'b0, 8'hA0);
        wait_grant("t5_wait");
        step();
        put(0, 1'b1, 1'b0, 8'hA1);
        settle();
        chk("t5_byte2", bus.tx_data, 8'hA1);
        reset_n = 1'b0;
        settle();
        chk("t5_async_grant", bus.grant, 0);
        chk("t5_async_valid", bus.tx_valid, 0);
        chk("t5_async_busy", bus.busy, 0);
        step();
        step();
        reset_n = 1'b1;
        bus.req = 4'b0011;
        put(0, 1'b1, 1'b1, 8'hB0);
        put(1, 1'b1, 1'b1, 8'hB1);
        wait_grant("t5_wait2");
        settle();
        chk("t5_first", bus.grant, 4'b0001);
        step();
        wait_grant("t5_wait3");
        chk("t5_second", bus.grant, 4'b0010);
        step();

        // Stalled owner: forced release with the timer, indefinite hold without it
        do_reset();
        bus.tx_ready = 1'b1;
        bus.req      = 4'b0011;
        put(0, 1'b1, 1'b0, 8'hC0);
        put(1, 1'b1, 1'b1, 8'hC1);
        wait_grant("t6_wait");
        settle();
        chk("t6_owner", bus.grant, 4'b0001);
        step();
        put(0, 1'b0, 1'b0, 8'h00);
        pulses = 0;
`ifdef ARB_TIMEOUT_EN
        begin : t6_timeout
            int pulse_k;
            pulse_k = -1;
            for (int k = 0; k <= 18; k++) begin
                settle();
                if (bus.timeout_pulse) begin
                    pulses++;
                    pulse_k = k;
                end
                exp_g = (k < TO) ? 1 : (k < TO + 2) ? 0 : 2;
                chk("t6_grant", bus.grant, exp_g);
                step();
            end
            chk("t6_pulse_count", pulses, 1);
            chk("t6_pulse_cycle", pulse_k, TO);
        end
`else
        begin : t6_hold
            int held;
            held = 1;
            for (int k = 0; k < 1000; k++) begin
                settle();
                if (bus.grant != 4'b0001) held = 0;
                if (bus.timeout_pulse) pulses++;
                step();
            end
            chk("t6_held", held, 1);
            chk("t6_no_pulse", pulses, 0);
        end
`endif

        // Randomized traffic against the message-level model
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
            mpos[i]    = 0;
            nm = $urandom_range(1, 3);
            for (int m = 0; m < nm; m++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    src_mem[i][src_len[i]] = {b == len - 1, 8'($urandom)};
                    src_len[i]++;
                end
            end
        end
        mptr = N - 1;
        for (int g = 0; g < 64; g++) begin
            found = -1;
            for (int k = 1; k <= N; k++) begin
                cidx = (mptr + k) % N;
                if (found < 0 && mpos[cidx] < src_len[cidx]) found = cidx;
            end
            if (found < 0) break;
            done_msg = 1'b0;
            while (!done_msg) begin
                exp_own.push_back(found);
                exp_byt.push_back(src_mem[found][mpos[found]]);
                done_msg = src_mem[found][mpos[found]][8];
                mpos[found]++;
            end
            mptr = found;
        end

        do_reset();
        cyc = 0;
        while (exp_own.size() > 0 && cyc < 4000) begin
            for (int i = 0; i < N; i++) begin
                if (src_pos[i] < src_len[i]) begin
                    bus.req[i] = 1'b1;
                    put(i, $urandom_range(0, 9) < 8, src_mem[i][src_pos[i]][8],
                        src_mem[i][src_pos[i]][7:0]);
                end else begin
                    bus.req[i] = 1'b0;
                    put(i, 1'b0, 1'b0, 8'h00);
                end
            end
            bus.tx_ready = ($urandom_range(0, 3) != 0);
            settle();
            if (bus.tx_valid && bus.tx_ready) begin
                chk("rnd_owner", bus.grant, 32'(1) << exp_own[0]);
                chk("rnd_data", bus.tx_data, exp_byt[0][7:0]);
                chk("rnd_ready", bus.req_ready, bus.grant);
                void'(exp_own.pop_front());
                void'(exp_byt.pop_front());
                for (int i = 0; i < N; i++) begin
                    if (bus.req_ready[i] && bus.req_valid[i]) src_pos[i]++;
                end
            end
            step();
            cyc++;
        end
        chk("rnd_all_sent", exp_own.size(), 0);
        idle_inputs();
        step();
        step();
        settle();
        chk("rnd_end_grant", bus.grant, 0);
        chk("rnd_end_busy", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
